// File: rtl/sw_pkg.sv
// Shared types for the switch-port ingress parser.
//   sw_state_e : parser FSM states
//   sw_entry_t : one FIFO entry, {eop, data}
//   HDR_BYTES  : DA + SA + LEN header bytes ahead of the payload
package sw_pkg;

  localparam int unsigned HDR_BYTES = 3;

  typedef enum logic [2:0] {
    StIdle,
    StSa,
    StLen,
    StPayload,
    StTail,
    StDiscard
  } sw_state_e;

  typedef struct packed {
    logic       eop;
    logic [7:0] data;
  } sw_entry_t;

endpackage

// File: rtl/sw_commit_fifo.sv
// Commit/rollback FIFO. Bytes are written speculatively at wr_ptr and become
// visible to the reader only once commit_ptr moves past them. A rollback
// rewinds wr_ptr to commit_ptr, discarding the uncommitted tail.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   wr_en_i/wr_entry_i  speculative write
//   commit_i          commit up to and including the entry written this cycle
//   rollback_i        discard all uncommitted entries
//   rd_en_i           consume the head entry (ignored when empty)
//   rd_valid_o/rd_entry_o  first-word fall-through head
//   free_o            entries not occupied (committed or not) counted from rd_ptr
module sw_commit_fifo
  import sw_pkg::*;
#(
  parameter int unsigned Depth = 64,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  sw_entry_t     wr_entry_i,
  input  logic          commit_i,
  input  logic          rollback_i,
  input  logic          rd_en_i,
  output logic          rd_valid_o,
  output sw_entry_t     rd_entry_o,
  output logic [Aw:0]   free_o
);

  localparam logic [Aw:0] PtrOne = (Aw + 1)'(1);
  localparam logic [Aw:0] DepthP = (Aw + 1)'(Depth);

  logic [Aw:0] wr_ptr_q, commit_ptr_q, rd_ptr_q;
  logic [Aw:0] wr_ptr_inc;
  sw_entry_t   mem_q [Depth];

  assign wr_ptr_inc = wr_ptr_q + PtrOne;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q[Aw-1:0]] <= wr_entry_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
    end else begin
      if (rollback_i) begin
        wr_ptr_q <= commit_ptr_q;
      end else if (wr_en_i) begin
        wr_ptr_q <= wr_ptr_inc;
        // Commit includes the entry being written this cycle (the eop byte).
        if (commit_i) commit_ptr_q <= wr_ptr_inc;
      end
      if (rd_en_i && rd_valid_o) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  assign rd_valid_o = (rd_ptr_q != commit_ptr_q);
  assign rd_entry_o = mem_q[rd_ptr_q[Aw-1:0]];
  // Wrap bit makes the pointer difference exact for 0..Depth occupied entries.
  assign free_o     = DepthP - (wr_ptr_q - rd_ptr_q);

endmodule

// File: rtl/sw_port_parser.sv
// Ingress stage of a switch port. Parses DA, SA, LEN, then LEN payload bytes
// from the framed serial byte stream, stores them in a commit/rollback FIFO
// and presents only complete, legal packets downstream (valid/ready, FWFT).
// Truncated, oversize and refused packets are dropped and counted.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   data_in, sw_enable_in    input byte and packet frame
//   read_out                 busy: a new packet cannot be accepted
//   out_valid/out_data/out_eop/out_ready  downstream byte handshake
//   pkt_cnt, drop_cnt        saturating committed/dropped packet counters
module sw_port_parser
  import sw_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             sw_enable_in,
  output logic             read_out,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_eop,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned Aw       = $clog2(DEPTH);
  localparam int unsigned NeedFree = MAX_LEN + HDR_BYTES;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  sw_state_e        state_q;
  logic [7:0]       remaining_q;
  logic [CNT_W-1:0] pkt_cnt_q, drop_cnt_q;
  logic             read_out_q;

  logic             wr_en, commit, rollback, truncate, len_ok, discard_end;
  sw_entry_t        wr_entry, rd_entry;
  logic [Aw:0]      free;

  assign len_ok = (32'(data_in) <= MAX_LEN);

  // FIFO controls act on the byte present this cycle, so they are combinational.
  always_comb begin
    wr_en    = 1'b0;
    commit   = 1'b0;
    rollback = 1'b0;
    case (state_q)
      StIdle: wr_en = sw_enable_in && !read_out_q;
      StSa: begin
        wr_en    = sw_enable_in;
        rollback = !sw_enable_in;
      end
      StLen: begin
        if (sw_enable_in && len_ok) begin
          wr_en  = 1'b1;
          commit = (data_in == 8'd0);
        end else begin
          rollback = 1'b1;
        end
      end
      StPayload: begin
        wr_en    = sw_enable_in;
        commit   = sw_enable_in && (remaining_q == 8'd1);
        rollback = !sw_enable_in;
      end
      default: ;
    endcase
    wr_entry.eop  = commit;
    wr_entry.data = data_in;
  end

  // Oversize LEN also rolls back, but its drop is counted when DISCARD ends.
  assign truncate    = rollback && !sw_enable_in;
  assign discard_end = (state_q == StDiscard) && !sw_enable_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      read_out_q  <= 1'b0;
    end else begin
      read_out_q <= (32'(free) < NeedFree);
      if (commit && (pkt_cnt_q != '1)) pkt_cnt_q <= pkt_cnt_q + CntOne;
      if ((truncate || discard_end) && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CntOne;
      case (state_q)
        StIdle: begin
          if (sw_enable_in) state_q <= read_out_q ? StDiscard : StSa;
        end
        StSa: state_q <= sw_enable_in ? StLen : StIdle;
        StLen: begin
          if (!sw_enable_in) begin
            state_q <= StIdle;
          end else if (!len_ok) begin
            state_q <= StDiscard;
          end else begin
            remaining_q <= data_in;
            state_q     <= (data_in == 8'd0) ? StTail : StPayload;
          end
        end
        StPayload: begin
          if (!sw_enable_in) begin
            state_q <= StIdle;
          end else begin
            remaining_q <= remaining_q - 8'd1;
            if (remaining_q == 8'd1) state_q <= StTail;
          end
        end
        StTail, StDiscard: begin
          if (!sw_enable_in) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  sw_commit_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_en_i    (wr_en),
    .wr_entry_i (wr_entry),
    .commit_i   (commit),
    .rollback_i (rollback),
    .rd_en_i    (out_ready),
    .rd_valid_o (out_valid),
    .rd_entry_o (rd_entry),
    .free_o     (free)
  );

  assign out_data = rd_entry.data;
  assign out_eop  = rd_entry.eop;
  assign read_out = read_out_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule
